// File: rtl/alu_op_sequencer.sv
// ============================================================================
// alu_op_sequencer : issues 8-bit instructions to a registered 4-bit ALU and
//                    writes its result back into ACC and the carry/zero flags
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
   parameter int unsigned ALU_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic [7:0] instr,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic       alu_cin,
   output logic [2:0] alu_sel,
   input  logic [3:0] alu_out,
   input  logic       alu_cout,
   output logic [3:0] acc,
   output logic [3:0] breg,
   output logic       flag_c,
   output logic       flag_z,
   output logic [3:0] out_data,
   output logic       out_valid,
   output logic       halted
);

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_LDB = 4'h2;
   localparam logic [3:0] OP_TRF = 4'h3;
   localparam logic [3:0] OP_INC = 4'h4;
   localparam logic [3:0] OP_ADD = 4'h5;
   localparam logic [3:0] OP_ADC = 4'h6;
   localparam logic [3:0] OP_SUB = 4'h7;
   localparam logic [3:0] OP_DEC = 4'h8;
   localparam logic [3:0] OP_OR  = 4'h9;
   localparam logic [3:0] OP_XOR = 4'hA;
   localparam logic [3:0] OP_AND = 4'hB;
   localparam logic [3:0] OP_NOT = 4'hC;
   localparam logic [3:0] OP_CMP = 4'hD;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   // WAIT covers the ALU_LAT-1 cycles between ISSUE and WB; counter runs down to 0
   localparam logic [2:0] C_WAIT_LOAD = 3'((ALU_LAT > 1) ? (ALU_LAT - 2) : 0);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_WB    = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_cnt;
   logic [2:0] w_cnt_nxt;
   logic       r_is_cmp;

   logic [3:0] w_op;
   logic [3:0] w_imm;
   logic       w_accept;
   logic       w_is_alu;
   logic [3:0] w_code;

   assign w_op        = instr[7:4];
   assign w_imm       = instr[3:0];
   assign instr_ready = (r_state == S_IDLE) & ~rst;
   assign w_accept    = instr_valid & instr_ready;
   assign w_is_alu    = (w_op >= OP_TRF) && (w_op <= OP_CMP);

   // {alu_sel, cin} for each ALU opcode
   always_comb begin
      w_code = 4'b0000;
      case (w_op)
         OP_TRF:  w_code = 4'b0000;
         OP_INC:  w_code = 4'b0001;
         OP_ADD:  w_code = 4'b0010;
         OP_ADC:  w_code = {3'b001, flag_c};
         OP_SUB:  w_code = 4'b0101;
         OP_DEC:  w_code = 4'b0110;
         OP_OR:   w_code = 4'b1000;
         OP_XOR:  w_code = 4'b1010;
         OP_AND:  w_code = 4'b1100;
         OP_NOT:  w_code = 4'b1110;
         OP_CMP:  w_code = 4'b0101;
         default: w_code = 4'b0000;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_op == OP_HLT)
                  w_state_nxt = S_HALT;
               else if (w_is_alu)
                  w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (ALU_LAT <= 1) begin
               w_state_nxt = S_WB;
            end else begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = C_WAIT_LOAD;
            end
         end
         S_WAIT: begin
            if (r_cnt == 3'd0)
               w_state_nxt = S_WB;
            else
               w_cnt_nxt = r_cnt - 3'd1;
         end
         S_WB:    w_state_nxt = S_IDLE;
         S_HALT:  w_state_nxt = S_HALT;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 3'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= 4'd0;
         breg      <= 4'd0;
         flag_c    <= 1'b0;
         flag_z    <= 1'b0;
         out_data  <= 4'd0;
         out_valid <= 1'b0;
         halted    <= 1'b0;
         alu_a     <= 4'd0;
         alu_b     <= 4'd0;
         alu_sel   <= 3'd0;
         alu_cin   <= 1'b0;
         r_is_cmp  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (w_accept) begin
            case (w_op)
               OP_NOP: ;
               OP_LDA: begin
                  acc    <= w_imm;
                  flag_z <= (w_imm == 4'd0);
               end
               OP_LDB: breg <= w_imm;
               OP_OUT: begin
                  out_data  <= acc;
                  out_valid <= 1'b1;
               end
               OP_HLT: halted <= 1'b1;
               default: begin
                  // ALU operands are frozen here and held until the next ALU op
                  alu_a              <= acc;
                  alu_b              <= breg;
                  {alu_sel, alu_cin} <= w_code;
                  r_is_cmp           <= (w_op == OP_CMP);
               end
            endcase
         end
         if (r_state == S_WB) begin
            if (!r_is_cmp)
               acc <= alu_out;
            flag_c <= alu_cout;
            flag_z <= (alu_out == 4'd0);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// tb_alu_op_sequencer : drives ALU_LAT=1 and ALU_LAT=3 sequencers against an
//                       instruction-level reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       instr_valid = 1'b0;
   logic [7:0] instr = 8'h00;
   int         cur = 0;
   int         lat = 1;

   wire       vld       [2];
   wire       rdy       [2];
   wire [3:0] alu_a     [2];
   wire [3:0] alu_b     [2];
   wire       alu_cin   [2];
   wire [2:0] alu_sel   [2];
   wire [3:0] alu_out   [2];
   wire       alu_cout  [2];
   wire [3:0] acc       [2];
   wire [3:0] breg      [2];
   wire       flag_c    [2];
   wire       flag_z    [2];
   wire [3:0] out_data  [2];
   wire       out_valid [2];
   wire       halted    [2];

   int n_vec = 0;
   int n_err = 0;

   logic [3:0] m_acc, m_breg;
   logic       m_c, m_z, m_halt;

   always #5 clk = ~clk;

   // external registered ALU, reached through the cpu_defs {alu_sel,cin} codes
   function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin, input logic [2:0] sel);
      case (sel)
         3'd0:    return {1'b0, a} + {4'd0, cin};
         3'd1:    return {1'b0, a} + {1'b0, b} + {4'd0, cin};
         3'd2:    return {1'b0, a} + {1'b0, ~b} + {4'd0, cin};
         3'd3:    return {1'b0, a} + 5'd15 + {4'd0, cin};
         3'd4:    return {1'b0, a | b};
         3'd5:    return {1'b0, a ^ b};
         3'd6:    return {1'b0, a & b};
         default: return {1'b0, ~a};
      endcase
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : 3;
      logic [4:0] pipe [LAT];

      assign vld[g] = instr_valid & (cur == g);

      alu_op_sequencer #(.ALU_LAT(LAT)) u_dut (
         .clk         (clk),
         .rst         (rst),
         .instr_valid (vld[g]),
         .instr_ready (rdy[g]),
         .instr       (instr),
         .alu_a       (alu_a[g]),
         .alu_b       (alu_b[g]),
         .alu_cin     (alu_cin[g]),
         .alu_sel     (alu_sel[g]),
         .alu_out     (alu_out[g]),
         .alu_cout    (alu_cout[g]),
         .acc         (acc[g]),
         .breg        (breg[g]),
         .flag_c      (flag_c[g]),
         .flag_z      (flag_z[g]),
         .out_data    (out_data[g]),
         .out_valid   (out_valid[g]),
         .halted      (halted[g])
      );

      always @(posedge clk) begin
         pipe[0] <= alu_f(alu_a[g], alu_b[g], alu_cin[g], alu_sel[g]);
         for (int k = LAT - 1; k > 0; k--)
            pipe[k] <= pipe[k-1];
      end
      assign alu_out[g]  = pipe[LAT-1][3:0];
      assign alu_cout[g] = pipe[LAT-1][4];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL L%0d %s: got %0h expected %0h", lat, tag, obs, exp_v);
      end
   endtask

   function automatic logic [3:0] exp_code(input logic [3:0] op, input logic c);
      case (op)
         4'h3: return 4'b0000;
         4'h4: return 4'b0001;
         4'h5: return 4'b0010;
         4'h6: return {3'b001, c};
         4'h7: return 4'b0101;
         4'h8: return 4'b0110;
         4'h9: return 4'b1000;
         4'hA: return 4'b1010;
         4'hB: return 4'b1100;
         4'hC: return 4'b1110;
         default: return 4'b0101;
      endcase
   endfunction

   task automatic check_state(input string tag);
      check({tag, ".acc"},    acc[cur],    m_acc);
      check({tag, ".breg"},   breg[cur],   m_breg);
      check({tag, ".c"},      flag_c[cur], m_c);
      check({tag, ".z"},      flag_z[cur], m_z);
      check({tag, ".halted"}, halted[cur], m_halt);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      instr_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("rst.ready", rdy[cur], 0);
      check("rst.sel",   {alu_sel[cur], alu_cin[cur]}, 0);
      check("rst.ab",    {alu_a[cur], alu_b[cur]}, 0);
      check("rst.out",   {out_valid[cur], out_data[cur]}, 0);
      m_acc = 0; m_breg = 0; m_c = 0; m_z = 0; m_halt = 0;
      check_state("rst");
      rst = 1'b0;
      @(negedge clk);
      check("rst.ready_after", rdy[cur], 1);
   endtask

   task automatic send(input logic [3:0] op, input logic [3:0] imm);
      int         n;
      int         wide;
      logic [3:0] r;
      logic       c_new;
      @(negedge clk);
      instr = {op, imm};
      instr_valid = 1'b1;
      n = 0;
      while (!rdy[cur] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!rdy[cur]) begin
         check("accept_timeout", rdy[cur], 1);
         instr_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);
      if (op >= 4'h3 && op <= 4'hD) begin
         check("alu_code", {alu_sel[cur], alu_cin[cur]}, exp_code(op, m_c));
         check("alu_a", alu_a[cur], m_acc);
         check("alu_b", alu_b[cur], m_breg);
         r = 0; c_new = 0;
         case (op)
            4'h3: r = m_acc;
            4'h4: begin wide = m_acc + 1;              r = wide[3:0]; c_new = (wide > 15); end
            4'h5: begin wide = m_acc + m_breg;         r = wide[3:0]; c_new = (wide > 15); end
            4'h6: begin wide = m_acc + m_breg + m_c;   r = wide[3:0]; c_new = (wide > 15); end
            4'h7, 4'hD: begin
               wide = m_acc - m_breg;
               r = wide[3:0];
               c_new = (m_acc >= m_breg);
            end
            4'h8: begin r = m_acc - 4'd1; c_new = (m_acc != 0); end
            4'h9: r = m_acc | m_breg;
            4'hA: r = m_acc ^ m_breg;
            4'hB: r = m_acc & m_breg;
            default: r = ~m_acc;
         endcase
         n = 0;
         while (!rdy[cur] && n < 20) begin
            n++;
            @(negedge clk);
         end
         check("busy_cycles", n, lat + 1);
         if (op != 4'hD) m_acc = r;
         m_c = c_new;
         m_z = (r == 0);
      end else begin
         case (op)
            4'h1: begin m_acc = imm; m_z = (imm == 0); end
            4'h2: m_breg = imm;
            4'hE: begin
               check("out.pulse", out_valid[cur], 1);
               check("out.data",  out_data[cur],  m_acc);
               @(negedge clk);
               check("out.end",   out_valid[cur], 0);
            end
            4'hF: m_halt = 1;
            default: ;
         endcase
         check("ready_after_1cyc", rdy[cur], (op != 4'hF));
      end
      check_state($sformatf("op%0h", op));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         cur = d;
         lat = (d == 0) ? 1 : 3;
         do_reset();

         send(4'h1, 4'h9); send(4'h2, 4'h8); send(4'h5, 4'h0);
         send(4'h1, 4'h2); send(4'h2, 4'h3); send(4'h6, 4'h0);
         send(4'h1, 4'h3); send(4'h2, 4'h3); send(4'h7, 4'h0);
         send(4'h1, 4'h2); send(4'h2, 4'h5); send(4'hD, 4'h0);
         send(4'h1, 4'hF); send(4'h4, 4'h0); send(4'h8, 4'h0);

         repeat (60) send(4'($urandom_range(0, 14)), 4'($urandom));

         send(4'h1, 4'h5); send(4'hE, 4'h0); send(4'hF, 4'h0);
         @(negedge clk);
         instr = 8'h50;
         instr_valid = 1'b1;
         repeat (5) begin
            @(negedge clk);
            check("halt.ready", rdy[cur], 0);
         end
         instr_valid = 1'b0;
         check_state("halt.add_ignored");

         // reset lands on the writeback edge of an in-flight ADD
         do_reset();
         send(4'h1, 4'h9); send(4'h2, 4'h8);
         @(negedge clk);
         instr = 8'h50;
         instr_valid = 1'b1;
         @(posedge clk);
         #1 instr_valid = 1'b0;
         repeat (lat + 1) @(negedge clk);
         check("wbrst.in_wb", rdy[cur], 0);
         rst = 1'b1;
         @(negedge clk);
         m_acc = 0; m_breg = 0; m_c = 0; m_z = 0; m_halt = 0;
         check_state("wbrst");
         check("wbrst.ready_in_rst", rdy[cur], 0);
         rst = 1'b0;
         @(negedge clk);
         check("wbrst.idle", rdy[cur], 1);
         check_state("wbrst.after");
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
